// File: rtl/gato_pkg.sv
// gato_pkg: quadrant constants, result encoding, button bundle and cursor-move helpers
// shared by the tic-tac-toe game controller.
package gato_pkg;

    localparam int unsigned N_CASILLAS = 9;
    localparam int unsigned QW         = 4;

    localparam logic [QW-1:0] Q_NINGUNO = 4'd0;
    localparam logic [QW-1:0] Q1 = 4'd1;
    localparam logic [QW-1:0] Q2 = 4'd2;
    localparam logic [QW-1:0] Q3 = 4'd3;
    localparam logic [QW-1:0] Q4 = 4'd4;
    localparam logic [QW-1:0] Q5 = 4'd5;
    localparam logic [QW-1:0] Q6 = 4'd6;
    localparam logic [QW-1:0] Q7 = 4'd7;
    localparam logic [QW-1:0] Q8 = 4'd8;
    localparam logic [QW-1:0] Q9 = 4'd9;

    typedef enum logic [1:0] {
        JUGANDO = 2'b00,
        GANA_X  = 2'b01,
        GANA_O  = 2'b10,
        EMPATE  = 2'b11
    } estado_t;

    // Field order is the event priority, highest first.
    typedef struct packed {
        logic nuevo;
        logic selec;
        logic arriba;
        logic abajo;
        logic izq;
        logic der;
    } botones_t;

    function automatic logic [QW-1:0] mover_arriba(input logic [QW-1:0] q);
        return (q inside {Q1, Q2, Q3}) ? q + QW'(6) : q - QW'(3);
    endfunction

    function automatic logic [QW-1:0] mover_abajo(input logic [QW-1:0] q);
        return (q inside {Q7, Q8, Q9}) ? q - QW'(6) : q + QW'(3);
    endfunction

    function automatic logic [QW-1:0] mover_izq(input logic [QW-1:0] q);
        return (q inside {Q1, Q4, Q7}) ? q + QW'(2) : q - QW'(1);
    endfunction

    function automatic logic [QW-1:0] mover_der(input logic [QW-1:0] q);
        return (q inside {Q3, Q6, Q9}) ? q - QW'(2) : q + QW'(1);
    endfunction

endpackage

// File: rtl/gato_linea_detect.sv
// gato_linea_detect: flags whether a 9-quadrant board holds a complete row,
// column or diagonal. Bit i-1 of the board is quadrant i.
module gato_linea_detect
    import gato_pkg::*;
(
    input  logic [N_CASILLAS-1:0] tablero_i,
    output logic                  linea_c_o
);

    assign linea_c_o = (&tablero_i[2:0]) | (&tablero_i[5:3]) | (&tablero_i[8:6])
                     | (tablero_i[0] & tablero_i[3] & tablero_i[6])
                     | (tablero_i[1] & tablero_i[4] & tablero_i[7])
                     | (tablero_i[2] & tablero_i[5] & tablero_i[8])
                     | (tablero_i[0] & tablero_i[4] & tablero_i[8])
                     | (tablero_i[2] & tablero_i[4] & tablero_i[6]);

endmodule

// File: rtl/gato_control_jugadas.sv
// gato_control_jugadas: button edges -> cursor, boards, turn and game result for the renderer.
// Define CURSOR_BLINK_EN to blink the displayed cursor with half-period BLINK_CICLOS.
module gato_control_jugadas
    import gato_pkg::*;
`ifdef CURSOR_BLINK_EN
#(
    parameter int unsigned BLINK_CICLOS = 12_500_000
)
`endif
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  btn_arriba,
    input  logic                  btn_abajo,
    input  logic                  btn_izq,
    input  logic                  btn_der,
    input  logic                  btn_selec,
    input  logic                  btn_nuevo,
    output logic [QW-1:0]         cuadrante,
    output logic [N_CASILLAS-1:0] tablero_x,
    output logic [N_CASILLAS-1:0] tablero_o,
    output logic                  turno,
    output logic [1:0]            estado,
    output logic                  jugada_valida
);

    botones_t              btn_c, hist_q, ev_c;
    estado_t               estado_q, estado_d;
    logic [QW-1:0]         cursor_q, cursor_d, cuadrante_q, cuadrante_d;
    logic [N_CASILLAS-1:0] tablero_x_q, tablero_x_d, tablero_o_q, tablero_o_d;
    logic [N_CASILLAS-1:0] ocupado_c, marca_c;
    logic                  turno_q, turno_d, valida_q, valida_d;
    logic                  gana_x_c, gana_o_c, mostrar_c;

    assign btn_c     = {btn_nuevo, btn_selec, btn_arriba, btn_abajo, btn_izq, btn_der};
    assign ev_c      = btn_c & ~hist_q;
    assign ocupado_c = tablero_x_q | tablero_o_q;
    assign marca_c   = N_CASILLAS'(1) << (cursor_q - QW'(1));

    gato_linea_detect u_linea_x (.tablero_i(tablero_x_q), .linea_c_o(gana_x_c));
    gato_linea_detect u_linea_o (.tablero_i(tablero_o_q), .linea_c_o(gana_o_c));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q <= JUGANDO;
        end else begin
            estado_q <= estado_d;
        end
    end

    // The result is judged from the registered boards, so it lands one cycle after the deciding mark.
    always_comb begin
        estado_d    = estado_q;
        cursor_d    = cursor_q;
        tablero_x_d = tablero_x_q;
        tablero_o_d = tablero_o_q;
        turno_d     = turno_q;
        valida_d    = 1'b0;
        if (ev_c.nuevo) begin
            estado_d    = JUGANDO;
            cursor_d    = Q5;
            tablero_x_d = '0;
            tablero_o_d = '0;
            turno_d     = 1'b0;
        end else if (estado_q == JUGANDO) begin
            if (gana_x_c) begin
                estado_d = GANA_X;
            end else if (gana_o_c) begin
                estado_d = GANA_O;
            end else if (&ocupado_c) begin
                estado_d = EMPATE;
            end
            if (ev_c.selec) begin
                if ((ocupado_c & marca_c) == '0) begin
                    if (turno_q) begin
                        tablero_o_d = tablero_o_q | marca_c;
                    end else begin
                        tablero_x_d = tablero_x_q | marca_c;
                    end
                    turno_d  = ~turno_q;
                    valida_d = 1'b1;
                end
            end else if (ev_c.arriba) begin
                cursor_d = mover_arriba(cursor_q);
            end else if (ev_c.abajo) begin
                cursor_d = mover_abajo(cursor_q);
            end else if (ev_c.izq) begin
                cursor_d = mover_izq(cursor_q);
            end else if (ev_c.der) begin
                cursor_d = mover_der(cursor_q);
            end
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int unsigned CNT_W = $clog2(BLINK_CICLOS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fase_q, fase_d;

    // Any reposition restarts the blink in the visible phase.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        fase_d = fase_q;
        if (ev_c.nuevo || (cursor_d != cursor_q)) begin
            cnt_d  = '0;
            fase_d = 1'b0;
        end else if (cnt_q == CNT_W'(BLINK_CICLOS - 1)) begin
            cnt_d  = '0;
            fase_d = ~fase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            fase_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fase_q <= fase_d;
        end
    end

    assign mostrar_c = ~fase_d;
`else
    assign mostrar_c = 1'b1;
`endif

    assign cuadrante_d = ((estado_d == JUGANDO) && mostrar_c) ? cursor_d : Q_NINGUNO;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q      <= '1;
            cursor_q    <= Q5;
            cuadrante_q <= Q5;
            tablero_x_q <= '0;
            tablero_o_q <= '0;
            turno_q     <= 1'b0;
            valida_q    <= 1'b0;
        end else begin
            hist_q      <= btn_c;
            cursor_q    <= cursor_d;
            cuadrante_q <= cuadrante_d;
            tablero_x_q <= tablero_x_d;
            tablero_o_q <= tablero_o_d;
            turno_q     <= turno_d;
            valida_q    <= valida_d;
        end
    end

    assign cuadrante     = cuadrante_q;
    assign tablero_x     = tablero_x_q;
    assign tablero_o     = tablero_o_q;
    assign turno         = turno_q;
    assign estado        = estado_q;
    assign jugada_valida = valida_q;

endmodule
